// File: rtl/reduce_arr_seq_module.sv
// Multi-cycle OR/AND/XOR reduction of a packed channel array, one channel per clock.
// Optional early exit on accumulator saturation: define REDUCE_EARLY_EXIT_EN.
module reduce_arr_seq_module #(
  parameter int WIDTH_I   = 4,
  parameter int WIDTH_I_X = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WIDTH_I-1:0][WIDTH_I_X-1:0] in,
  input  logic                              in_valid,
  input  logic [1:0]                        mode,
  output logic                              in_ready,
  output logic                              busy,
  output logic [WIDTH_I_X-1:0]              out_vec,
  output logic                              out,
  output logic                              out_valid
);

  localparam int IW = $clog2(WIDTH_I);
  localparam logic [IW-1:0] LAST = IW'(WIDTH_I - 1);
  localparam logic [1:0] M_OR  = 2'b00;
  localparam logic [1:0] M_AND = 2'b01;
  localparam logic [1:0] M_XOR = 2'b10;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH_I-1:0][WIDTH_I_X-1:0] arr;
  logic [WIDTH_I_X-1:0]              acc;
  logic [IW-1:0]                     idx;
  logic [1:0]                        mode_q;

  logic [1:0]           cap_mode;
  logic [WIDTH_I_X-1:0] acc_nx;
  logic                 cap;
  logic                 last;
  logic                 cap_exit;
  logic                 scan_exit;
  logic                 res_fire;
  logic [WIDTH_I_X-1:0] res_vec;
  logic [1:0]           res_mode;

  function automatic logic [WIDTH_I_X-1:0] fold(
    input logic [WIDTH_I_X-1:0] a,
    input logic [WIDTH_I_X-1:0] b,
    input logic [1:0]           m
  );
    case (m)
      M_AND:   fold = a & b;
      M_XOR:   fold = a ^ b;
      default: fold = a | b;
    endcase
  endfunction

  function automatic logic reduce(
    input logic [WIDTH_I_X-1:0] v,
    input logic [1:0]           m
  );
    case (m)
      M_AND:   reduce = &v;
      M_XOR:   reduce = ^v;
      default: reduce = |v;
    endcase
  endfunction

`ifdef REDUCE_EARLY_EXIT_EN
  function automatic logic sat(
    input logic [WIDTH_I_X-1:0] v,
    input logic [1:0]           m
  );
    sat = ((m == M_OR) && (&v)) ||
          ((m == M_AND) && !(|v));
  endfunction
`endif

  always_comb begin
    cap_mode = (mode == 2'b11) ? M_OR : mode;
    cap      = (state == IDLE) && in_valid;
    acc_nx   = fold(acc, arr[idx], mode_q);
    last     = (idx == LAST);
`ifdef REDUCE_EARLY_EXIT_EN
    cap_exit  = sat(in[0], cap_mode);
    scan_exit = last || sat(acc_nx, mode_q);
`else
    cap_exit  = 1'b0;
    scan_exit = last;
`endif
    res_fire = (cap && cap_exit) ||
               ((state == SCAN) && scan_exit);
    res_vec  = (state == IDLE) ? in[0] : acc_nx;
    res_mode = (state == IDLE) ? cap_mode : mode_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cap) state_nx = cap_exit ? DONE : SCAN;
      SCAN: if (scan_exit) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == SCAN) || (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr       <= '0;
      acc       <= '0;
      idx       <= '0;
      mode_q    <= M_OR;
      out_vec   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (cap) begin
        arr    <= in;
        mode_q <= cap_mode;
        acc    <= in[0];
        idx    <= IW'(1);
      end else if (state == SCAN) begin
        acc <= acc_nx;
        if (!last) idx <= idx + IW'(1);
      end
      if (res_fire) begin
        out_vec <= res_vec;
        out     <= reduce(res_vec, res_mode);
      end
      out_valid <= res_fire;
    end
  end

endmodule

// File: tb/tb_reduce_arr_seq_module.sv
// Bench for reduce_arr_seq_module: job-level timing model plus directed jobs.
// Honours REDUCE_EARLY_EXIT_EN for the expected latencies.
module tb_reduce_arr_seq_module;

  localparam int W = 4;
  localparam int X = 2;

`ifdef REDUCE_EARLY_EXIT_EN
  localparam int L_OR_SAT = 0;
  localparam int L_AND    = 2;
  localparam bit EARLY    = 1'b1;
`else
  localparam int L_OR_SAT = 3;
  localparam int L_AND    = 3;
  localparam bit EARLY    = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [W-1:0][X-1:0] in;
  logic               in_valid;
  logic [1:0]         mode;
  logic               in_ready;
  logic               busy;
  logic [X-1:0]       out_vec;
  logic               out;
  logic               out_valid;

  int checks = 0;
  int errors = 0;

  reduce_arr_seq_module #(.WIDTH_I(W), .WIDTH_I_X(X)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .in_valid(in_valid),
    .mode(mode),
    .in_ready(in_ready),
    .busy(busy),
    .out_vec(out_vec),
    .out(out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm,
                              input int act,
                              input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic logic [1:0] eff(input logic [1:0] md);
    return (md == 2'b11) ? 2'b00 : md;
  endfunction

  function automatic logic [X-1:0] f_vec(
    input logic [W-1:0][X-1:0] a, input logic [1:0] md);
    logic [X-1:0] v;
    v = a[0];
    for (int i = 1; i < W; i++)
      case (eff(md))
        2'b01:   v = v & a[i];
        2'b10:   v = v ^ a[i];
        default: v = v | a[i];
      endcase
    return v;
  endfunction

  function automatic logic f_out(
    input logic [W-1:0][X-1:0] a, input logic [1:0] md);
    logic [X-1:0] v;
    v = f_vec(a, md);
    case (eff(md))
      2'b01:   return &v;
      2'b10:   return ^v;
      default: return |v;
    endcase
  endfunction

  function automatic int f_lat(
    input logic [W-1:0][X-1:0] a, input logic [1:0] md);
    logic [X-1:0] v;
    logic [1:0] m;
    m = eff(md);
    v = a[0];
    for (int i = 0; i < W; i++) begin
      if (i > 0)
        v = (m == 2'b01) ? (v & a[i]) :
            (m == 2'b10) ? (v ^ a[i]) : (v | a[i]);
      if (EARLY && m == 2'b00 && v == {X{1'b1}}) return i;
      if (EARLY && m == 2'b01 && v == '0) return i;
    end
    return W - 1;
  endfunction

  logic         m_ready, m_valid, m_out, p_out;
  logic [X-1:0] m_vec, p_vec;
  int           cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_vec   <= '0;
      m_out   <= 1'b0;
      p_vec   <= '0;
      p_out   <= 1'b0;
      cnt     <= 0;
    end else if (m_valid) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end else if (m_ready) begin
      if (in_valid) begin
        m_ready <= 1'b0;
        if (f_lat(in, mode) == 0) begin
          m_valid <= 1'b1;
          m_vec   <= f_vec(in, mode);
          m_out   <= f_out(in, mode);
        end else begin
          cnt   <= f_lat(in, mode);
          p_vec <= f_vec(in, mode);
          p_out <= f_out(in, mode);
        end
      end
    end else begin
      if (cnt == 1) begin
        m_valid <= 1'b1;
        m_vec   <= p_vec;
        m_out   <= p_out;
      end
      cnt <= cnt - 1;
    end
  end

  always @(negedge clk) begin
    chk("cyc in_ready", int'(in_ready), int'(m_ready));
    chk("cyc busy", int'(busy), int'(!m_ready));
    chk("cyc out_valid", int'(out_valid), int'(m_valid));
    chk("cyc out_vec", int'(out_vec), int'(m_vec));
    chk("cyc out", int'(out), int'(m_out));
  end

  task automatic run_job(input string nm,
                         input logic [W-1:0][X-1:0] a,
                         input logic [1:0] md,
                         input logic [X-1:0] ev,
                         input logic eo,
                         input int el,
                         input bit hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready"}, int'(in_ready), 1);
    in = a;
    mode = md;
    in_valid = 1'b1;
    @(negedge clk);
    in = ~a;
    if (hold) mode = 2'b01;
    else in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      if (hold) chk({nm, " ready low"}, int'(in_ready), 0);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, n, el);
    chk({nm, " vec"}, int'(out_vec), int'(ev));
    chk({nm, " out"}, int'(out), int'(eo));
    @(negedge clk);
  endtask

  initial begin
    in = '0;
    in_valid = 1'b0;
    mode = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst out_vec", int'(out_vec), 0);
    chk("rst out", int'(out), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst in_ready", int'(in_ready), 1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    run_job("or sat", 8'b00_01_10_11, 2'b00, 2'b11, 1'b1, L_OR_SAT, 1'b0);
    run_job("or plain", 8'b00_00_10_10, 2'b00, 2'b10, 1'b1, 3, 1'b0);
    run_job("and", 8'b01_01_10_11, 2'b01, 2'b00, 1'b0, L_AND, 1'b0);
    run_job("xor a", 8'b01_01_10_11, 2'b10, 2'b01, 1'b1, 3, 1'b0);
    run_job("xor b", 8'b00_01_10_11, 2'b10, 2'b00, 1'b0, 3, 1'b0);
    run_job("hold", 8'b00_00_10_10, 2'b00, 2'b10, 1'b1, 3, 1'b1);
    run_job("mode11", 8'b00_00_10_10, 2'b11, 2'b10, 1'b1, 3, 1'b0);

    in = 8'b11_11_11_11;
    mode = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst in_ready", int'(in_ready), 1);
    chk("mid rst out_vec", int'(out_vec), 0);
    chk("mid rst out_valid", int'(out_valid), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no valid", int'(out_valid), 0);
    end
    run_job("after rst", 8'b00_01_10_11, 2'b10, 2'b00, 1'b0, 3, 1'b0);
    run_job("and full", 8'b11_11_11_11, 2'b01, 2'b11, 1'b1, 3, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
